clarke_transform_pipe: RTL

Pipelined, parametrised Clarke (abc → αβ0) transform for the current-control path. It accepts one signed fixed-point three-phase current sample per valid handshake. It produces amplitude-invariant α, β and zero-sequence outputs with rounding and saturation, and exposes a sticky saturation flag. It runs in either three-sensor or two-sensor (a, b only) mode, selected per sample. It sits between the ADC sample formatter and the Park transform.

---
 rtl/clarke_transform_pipe_if.sv | 29 ++
 rtl/clarke_transform_pipe.sv | 133 +++++++++++++
 2 files changed

// File: rtl/clarke_transform_pipe_if.sv
// Sample/result bundle for the Clarke transform pipeline.
// The slave modport is the transform side; the master modport is the producer/consumer side.
interface clarke_transform_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] i_a;
  logic signed [WIDTH-1:0] i_b;
  logic signed [WIDTH-1:0] i_c;
  logic                    mode_2s;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] i_alpha;
  logic signed [WIDTH-1:0] i_beta;
  logic signed [WIDTH-1:0] i_zero;
  logic                    sat_flag;
  logic                    sat_clr;

  modport master (
    output in_valid, i_a, i_b, i_c, mode_2s, out_ready, sat_clr,
    input  in_ready, out_valid, i_alpha, i_beta, i_zero, sat_flag
  );

  modport slave (
    input  in_valid, i_a, i_b, i_c, mode_2s, out_ready, sat_clr,
    output in_ready, out_valid, i_alpha, i_beta, i_zero, sat_flag
  );
endinterface

// File: rtl/clarke_transform_pipe.sv
// Three-stage amplitude-invariant Clarke transform (abc -> alpha/beta/zero) with rounding,
// saturation, a sticky saturation flag and per-sample three/two-sensor mode.
module clarke_transform_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 18,
  // round(2^(CW-1)/3) and round(2^(CW-1)/sqrt(3)); must be updated together with CW
  parameter int unsigned K3    = 43691,
  parameter int unsigned KS3   = 75675
) (
  input logic                    clk,
  input logic                    rst_n,
  clarke_transform_pipe_if.slave bus
);

  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned PW = SW + CW;

  localparam logic signed [PW-1:0] CoefK3  = PW'(K3);
  localparam logic signed [PW-1:0] CoefKs3 = PW'(KS3);
  localparam logic signed [PW-1:0] CoefOne = PW'(2 ** (CW - 1));
  localparam logic signed [PW-1:0] Half    = PW'(2 ** (CW - 2));
  localparam logic signed [PW-1:0] SatMax  = PW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [PW-1:0] SatMin  = -SatMax - PW'(1);

  // Returns {saturated, value}; rounding is half toward +inf.
  function automatic logic [WIDTH:0] rnd_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + Half) >>> (CW - 1);
    if (t > SatMax)      return {1'b1, SatMax[WIDTH-1:0]};
    else if (t < SatMin) return {1'b1, SatMin[WIDTH-1:0]};
    else                 return {1'b0, t[WIDTH-1:0]};
  endfunction

  logic                    stall, adv;
  logic                    v1_q, v2_q, v3_q, mode1_q, sat_q;
  logic signed [SW-1:0]    s_al_q, s_be_q, s_ze_q, s_al_d, s_be_d, s_ze_d;
  logic signed [SW-1:0]    a_x, b_x, c_x;
  logic signed [PW-1:0]    p_al_q, p_be_q, p_ze_q, p_al_d, p_be_d, p_ze_d;
  logic signed [WIDTH-1:0] al_q, be_q, ze_q, al_d, be_d, ze_d;
  logic [WIDTH:0]          r_al, r_be, r_ze;
  logic                    sat_any;

  assign stall = v3_q && !bus.out_ready;
  assign adv   = !stall;

  always_comb begin
    a_x = SW'(bus.i_a);
    b_x = SW'(bus.i_b);
    c_x = SW'(bus.i_c);
    s_al_d = (a_x <<< 1) - b_x - c_x;
    s_be_d = b_x - c_x;
    s_ze_d = a_x + b_x + c_x;
    if (bus.mode_2s) begin
      s_al_d = a_x;
      s_be_d = a_x + (b_x <<< 1);
      s_ze_d = '0;
    end
  end

  // Two-sensor alpha is scaled by exactly 2^(CW-1) so rounding returns a unchanged.
  always_comb begin
    p_al_d = PW'(s_al_q) * (mode1_q ? CoefOne : CoefK3);
    p_be_d = PW'(s_be_q) * CoefKs3;
    p_ze_d = PW'(s_ze_q) * CoefK3;
  end

  always_comb begin
    r_al    = rnd_sat(p_al_q);
    r_be    = rnd_sat(p_be_q);
    r_ze    = rnd_sat(p_ze_q);
    al_d    = r_al[WIDTH-1:0];
    be_d    = r_be[WIDTH-1:0];
    ze_d    = r_ze[WIDTH-1:0];
    sat_any = r_al[WIDTH] | r_be[WIDTH] | r_ze[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      mode1_q <= 1'b0;
      s_al_q  <= '0;
      s_be_q  <= '0;
      s_ze_q  <= '0;
      p_al_q  <= '0;
      p_be_q  <= '0;
      p_ze_q  <= '0;
      al_q    <= '0;
      be_q    <= '0;
      ze_q    <= '0;
    end else if (adv) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.in_valid) begin
        mode1_q <= bus.mode_2s;
        s_al_q  <= s_al_d;
        s_be_q  <= s_be_d;
        s_ze_q  <= s_ze_d;
      end
      if (v1_q) begin
        p_al_q <= p_al_d;
        p_be_q <= p_be_d;
        p_ze_q <= p_ze_d;
      end
      if (v2_q) begin
        al_q <= al_d;
        be_q <= be_d;
        ze_q <= ze_d;
      end
    end
  end

  // Clear wins over a same-cycle set; that saturation event is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (bus.sat_clr) begin
      sat_q <= 1'b0;
    end else if (adv && v2_q && sat_any) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = v3_q;
  assign bus.i_alpha   = al_q;
  assign bus.i_beta    = be_q;
  assign bus.i_zero    = ze_q;
  assign bus.sat_flag  = sat_q;

endmodule
